encoder_4_to_2_serial: RTL

Sequential 4-to-2 encoder, the inverse of the team's 2-bit one-hot decoder. Accepts a 4-bit request word on a valid/ready handshake and emits, one per output handshake, the 2-bit index of every set bit, lowest index first. Used where a multi-bit request or status vector must be serialised into binary indices for a downstream decoder or controller.

---
 rtl/encoder_4_to_2_serial_if.sv | 34 +++
 rtl/encoder_4_to_2_serial.sv | 80 ++++++++
 2 files changed

// File: rtl/encoder_4_to_2_serial_if.sv
// rtl/encoder_4_to_2_serial_if.sv - request/index handshake bundle for encoder_4_to_2_serial
// err exists only when ENCODER_ZERO_ERR_EN is defined.
interface encoder_4_to_2_serial_if #(
  parameter int N     = 4,
  parameter int IDX_W = 2
);
  logic [N-1:0]     in;
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] out;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
`ifdef ENCODER_ZERO_ERR_EN
  logic             err;
`endif

  // master: the side that offers words and consumes indices
  modport master (
    output in, in_valid, out_ready,
    input  in_ready, out, out_valid, out_last
`ifdef ENCODER_ZERO_ERR_EN
    , input err
`endif
  );

  modport slave (
    input  in, in_valid, out_ready,
    output in_ready, out, out_valid, out_last
`ifdef ENCODER_ZERO_ERR_EN
    , output err
`endif
  );
endinterface

// File: rtl/encoder_4_to_2_serial.sv
// rtl/encoder_4_to_2_serial.sv - serialises a 4-bit request word into indices of its set bits, lowest first
// Optional ENCODER_ZERO_ERR_EN adds a one-cycle err pulse when an all-zero word is accepted.
module encoder_4_to_2_serial (
  input  logic                   clk,
  input  logic                   rst,
  encoder_4_to_2_serial_if.slave bus
);
  localparam int N     = 4;
  localparam int IDX_W = 2;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state, state_nxt;
  logic [N-1:0]     pend, pend_nxt, clr_mask;
  logic [IDX_W-1:0] idx;
  logic             last;
  logic             accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pend  <= '0;
    end else begin
      state <= state_nxt;
      pend  <= pend_nxt;
    end
  end

  // Lowest set bit wins: scan downward so the last hit is the smallest index.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pend[i]) idx = IDX_W'(i);
    end
  end

  assign last     = (pend != '0) && ((pend & (pend - N'(1))) == '0);
  assign clr_mask = N'(1) << idx;
  assign accept   = (state == IDLE) && bus.in_valid && !rst;

  always_comb begin
    state_nxt     = state;
    pend_nxt      = pend;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out       = '0;
    bus.out_last  = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = !rst;
        if (accept) begin
          pend_nxt = bus.in;
          if (bus.in != '0) state_nxt = SCAN;
        end
      end
      SCAN: begin
        bus.out_valid = 1'b1;
        bus.out       = idx;
        bus.out_last  = last;
        if (bus.out_ready) begin
          pend_nxt = pend & ~clr_mask;
          if (last) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef ENCODER_ZERO_ERR_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= accept && (bus.in == '0);
  end

  assign bus.err = err_q;
`endif

endmodule
